// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the RAM write/read-back BIST sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_bist_pkg;

  localparam int         BIST_DATA_W   = 8;
  localparam int         BIST_ADDR_W   = 8;
  localparam int         BIST_DEPTH    = 256;
  localparam int         BIST_READ_LAT = 2;
  localparam logic [7:0] BIST_SEED     = 8'h5A;

  // Sequencer phases, in the order a test walks through them.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } bist_state_t;

endpackage

// File: rtl/ram_bist_dly.sv
// Delay line pairing each issued read address with the RAM data that answers it.
// Latency: LAT cycles from in_vld/in_addr to out_vld/out_addr.
// Backpressure: none; shifts every cycle, synchronous clr empties every stage.
module ram_bist_dly
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int LAT    = BIST_READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr
);

  logic [LAT-1:0]    vld_sr;
  logic [ADDR_W-1:0] addr_sr [LAT];

  // Shift {valid, addr} one stage per cycle; clr drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < LAT; i++) addr_sr[i] <= '0;
    end else if (clr) begin
      vld_sr <= '0;
      for (int i = 0; i < LAT; i++) addr_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= in_vld;
      addr_sr[0] <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

  assign out_vld  = vld_sr[LAT-1];
  assign out_addr = addr_sr[LAT-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// Fills one RAM port with an address-derived pattern, reads it back and checks q.
// Latency: done rises 2*DEPTH+READ_LAT+1 cycles after start is accepted.
// Backpressure: none; start is only honoured in IDLE/DONE. Error log: RAM_BIST_ERRLOG_EN.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int              DATA_W   = BIST_DATA_W,
  parameter int              ADDR_W   = BIST_ADDR_W,
  parameter int              DEPTH    = BIST_DEPTH,
  parameter int              READ_LAT = BIST_READ_LAT,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(BIST_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(READ_LAT - 1);

  // Expected word for an address: address (zero-extended or truncated) plus SEED.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) + SEED;
  endfunction

  bist_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              wren_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [2:0]        drain_cnt, drain_cnt_nxt;
  logic              accept;
  logic              push;
  logic              finish;

  logic              dly_vld;
  logic [ADDR_W-1:0] dly_addr;
  logic              mismatch;
  logic              errs_seen;

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = address;
    data_nxt      = data;
    wren_nxt      = wren;
    busy_nxt      = busy;
    done_nxt      = done;
    drain_cnt_nxt = drain_cnt;
    accept        = 1'b0;
    push          = 1'b0;
    finish        = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = WRITE;
          addr_nxt  = '0;
          data_nxt  = pattern('0);
          wren_nxt  = 1'b1;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
        end
      end
      WRITE: begin
        if (address == LAST_ADDR) begin
          // Explicit clear keeps DEPTH == 2**ADDR_W from relying on wrap.
          state_nxt = READ;
          addr_nxt  = '0;
          data_nxt  = '0;
          wren_nxt  = 1'b0;
        end else begin
          addr_nxt = address + 1'b1;
          data_nxt = pattern(address + 1'b1);
        end
      end
      READ: begin
        push = 1'b1;
        if (address == LAST_ADDR) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = '0;
        end else begin
          addr_nxt = address + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          finish    = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and RAM-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      address   <= '0;
      data      <= '0;
      wren      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      address   <= addr_nxt;
      data      <= data_nxt;
      wren      <= wren_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  ram_bist_dly #(
    .ADDR_W (ADDR_W),
    .LAT    (READ_LAT)
  ) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .in_vld   (push),
    .in_addr  (address),
    .out_vld  (dly_vld),
    .out_addr (dly_addr)
  );

  assign mismatch = dly_vld && (q != pattern(dly_addr));

`ifdef RAM_BIST_ERRLOG_EN
  logic [ADDR_W:0]   err_cnt_q;
  logic [ADDR_W-1:0] err_addr_q;

  // Saturating mismatch count; the address is captured on the first miss only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (accept) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (mismatch) begin
      if (err_cnt_q == '0) err_addr_q <= dly_addr;
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign err_addr  = err_addr_q;
  assign errs_seen = (err_cnt_q != '0);
`else
  logic fail_q;

  // Sticky flag: any mismatch since the last accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q <= 1'b0;
    end else if (accept) begin
      fail_q <= 1'b0;
    end else if (mismatch) begin
      fail_q <= 1'b1;
    end
  end

  assign err_cnt   = '0;
  assign err_addr  = '0;
  assign errs_seen = fail_q;
`endif

  // Verdict is taken on the DONE edge and includes the final compare of that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass <= 1'b0;
    end else if (accept) begin
      pass <= 1'b0;
    end else if (finish) begin
      pass <= !(errs_seen || mismatch);
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench: default-size controller on a behavioural RAM with fault modes,
// plus a small DEPTH=4 / READ_LAT=1 instance on an ideal RAM.
// Error-log expectations follow RAM_BIST_ERRLOG_EN.
module tb_ram_bist_ctrl;

`ifdef RAM_BIST_ERRLOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic [7:0] q;
  logic [7:0] address;
  logic [7:0] data;
  logic       wren, busy, done, pass;
  logic [8:0] err_cnt;
  logic [7:0] err_addr;

  logic       start_s;
  logic [7:0] q_s;
  logic [7:0] address_s;
  logic [7:0] data_s;
  logic       wren_s, busy_s, done_s, pass_s;
  logic [8:0] err_cnt_s;
  logic [7:0] err_addr_s;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int dc;

  ram_bist_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .q        (q),
    .address  (address),
    .data     (data),
    .wren     (wren),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .err_addr (err_addr)
  );

  ram_bist_ctrl #(.DEPTH(4), .READ_LAT(1)) dut_s (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .q        (q_s),
    .address  (address_s),
    .data     (data_s),
    .wren     (wren_s),
    .busy     (busy_s),
    .done     (done_s),
    .pass     (pass_s),
    .err_cnt  (err_cnt_s),
    .err_addr (err_addr_s)
  );

  // RAM model, two-cycle read; mode 1 corrupts addr 8'h10, mode 2 reads all zero.
  logic [7:0] mem [256];
  logic [7:0] p0;

  function automatic logic [7:0] rd(input logic [7:0] a);
    case (mode)
      1:       rd = (a == 8'h10) ? 8'h00 : mem[a];
      2:       rd = 8'h00;
      default: rd = mem[a];
    endcase
  endfunction

  always @(posedge clk) begin
    if (wren) mem[address] <= data;
    p0 <= rd(address);
    q  <= p0;
  end

  // Ideal single-cycle-read RAM for the small instance.
  logic [7:0] mem_s [256];
  always @(posedge clk) begin
    if (wren_s) mem_s[address_s] <= data_s;
    q_s <= mem_s[address_s];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a run on the big instance; optionally re-pulse start in cycle `repulse`.
  // Returns the cycle number (start edge = E0) in which done is first seen.
  task automatic run(input int repulse, output int dcyc);
    int cyc;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    chk("c1_wren", 32'(wren), 1);
    chk("c1_addr", 32'(address), 0);
    chk("c1_data", 32'(data), 'h5A);
    chk("c1_busy", 32'(busy), 1);
    chk("c1_done", 32'(done), 0);
    while (done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      start = (cyc == repulse);
    end
    start = 1'b0;
    dcyc  = cyc;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", 32'({address, data, wren, busy, done, pass, err_cnt, err_addr}), 0);
    chk("rst_outs_s", 32'({address_s, data_s, wren_s, busy_s, done_s, pass_s}), 0);
    @(negedge clk); rst_n = 1'b1;

    // Ideal RAM.
    run(0, dc);
    chk("ideal_done_cyc", 32'(dc), 515);
    chk("ideal_pass", 32'(pass), 1);
    chk("ideal_errcnt", 32'(err_cnt), 0);
    chk("ideal_erraddr", 32'(err_addr), 0);
    chk("ideal_busy", 32'(busy), 0);
    chk("mem_0", 32'(mem[0]), 'h5A);
    chk("mem_255", 32'(mem[255]), 'h59);
    chk("mem_a6", 32'(mem[8'hA6]), 'h00);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", 32'(done), 1);
    chk("hold_pass", 32'(pass), 1);

    // One corrupted location; start from DONE reruns.
    mode = 1;
    run(0, dc);
    chk("corrupt_done_cyc", 32'(dc), 515);
    chk("corrupt_pass", 32'(pass), 0);
    chk("corrupt_errcnt", 32'(err_cnt), LOG ? 1 : 0);
    chk("corrupt_erraddr", 32'(err_addr), LOG ? 'h10 : 0);

    // Stuck-at-0: only 8'hA6 matches.
    mode = 2;
    run(0, dc);
    chk("stuck_pass", 32'(pass), 0);
    chk("stuck_errcnt", 32'(err_cnt), LOG ? 255 : 0);
    chk("stuck_erraddr", 32'(err_addr), 0);

    // Start re-pulsed mid-WRITE is ignored.
    mode = 0;
    run(100, dc);
    chk("repulse_done_cyc", 32'(dc), 515);
    chk("repulse_pass", 32'(pass), 1);
    chk("repulse_errcnt", 32'(err_cnt), 0);

    // Reset during READ aborts, then a fresh run passes.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (299) @(posedge clk);
    #1;
    chk("midread_wren", 32'(wren), 0);
    chk("midread_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({address, data, wren, busy, done, pass, err_cnt, err_addr}), 0);
    @(negedge clk); rst_n = 1'b1;
    run(0, dc);
    chk("after_rst_done_cyc", 32'(dc), 515);
    chk("after_rst_pass", 32'(pass), 1);

    // Small instance: DEPTH=4, READ_LAT=1 -> done in cycle 10.
    @(negedge clk); start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0; dc = 1;
    chk("s_c1_data", 32'(data_s), 'h5A);
    while (done_s !== 1'b1 && dc < 200) begin
      @(posedge clk); #1; dc++;
    end
    chk("s_done_cyc", 32'(dc), 10);
    chk("s_pass", 32'(pass_s), 1);
    chk("s_errcnt", 32'(err_cnt_s), 0);
    chk("s_busy", 32'(busy_s), 0);
    chk("s_mem3", 32'(mem_s[3]), 'h5D);
    chk("s_addr_hold", 32'(address_s), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Single-clock write/read-back sequencer for one port of the team's 8-bit dual-port RAM. On `start` it fills every location with a deterministic address-derived pattern, then reads every location back. It compares `q` against the expected value and reports pass/fail. It sits directly upstream of the RAM port, driving `address`/`data`/`wren`, and also consumes that port's `q`. It replaces the free-running RAM controller when a checked fill is needed.

## Interface
- `DATA_W`, default 8: RAM word width.
- `ADDR_W`, default 8: RAM address width.
- `DEPTH`, default 256: number of locations tested, 2 ≤ DEPTH ≤ 2^ADDR_W.
- `READ_LAT`, default 2: cycles from `address` presented to matching `q` valid, 1..4.
- `SEED`, default 8'h5A: pattern offset.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin test; sampled in IDLE or DONE only.
- `q` in DATA_W: RAM read data.
- `address` out ADDR_W: RAM address.
- `data` out DATA_W: RAM write data.
- `wren` out 1: RAM write enable.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: test finished; held until the next accepted `start`.
- `pass` out 1: valid while `done`; 1 means zero mismatches.
- `err_cnt` out ADDR_W+1: mismatch count, saturating at all-ones.
- `err_addr` out ADDR_W: address of the first mismatch.

## Operation
- FSM states: IDLE → WRITE → READ → DRAIN → DONE. DONE + `start` → WRITE.
- Pattern: expected(a) = (a + SEED) mod 2^DATA_W, where `a` is zero-extended or truncated to DATA_W.
- **WRITE**
  - `wren`=1; `address` steps 0..DEPTH-1, one per cycle; `data`=expected(address).
  - After address DEPTH-1 → READ with the address counter cleared.
- **READ**
  - `wren`=0; `address` steps 0..DEPTH-1; `data` holds 0.
  - Each issued address pushes {valid, addr} into a READ_LAT-deep delay line.
- **DRAIN**
  - Entered after address DEPTH-1 is issued.
  - Lasts READ_LAT cycles; `address` holds DEPTH-1.
- **Compare**
  - Whenever the delay-line output is valid, `q` is compared against expected(delayed addr).
  - On mismatch, `err_cnt` increments, saturating.
- **DONE**
  - `done`=1, `busy`=0, `pass`=(err_cnt==0).
  - Results are frozen until the next `start`.
- **Start handling**
  - `start` is ignored in WRITE/READ/DRAIN.
  - Accepting `start` clears err_cnt, err_addr, done and the delay line.
- Address counter width is ADDR_W. DEPTH == 2^ADDR_W wraps to 0 exactly at the WRITE→READ transition, with no overrun.

## Timing
- Reset (async assert, sync-released by the system): state=IDLE.
- All outputs reset to 0: `address`, `data`, `wren`, `busy`, `done`, `pass`, `err_cnt`, `err_addr`.
- Reset mid-test aborts immediately. No partial result is reported, and the RAM contents are left undefined.
- Start accepted at edge E0:
  - Write to address 0 occurs in cycle 1; writes span cycles 1..DEPTH.
  - Reads span cycles DEPTH+1..2·DEPTH.
  - The last compare happens in cycle 2·DEPTH+READ_LAT.
  - `done` rises in cycle 2·DEPTH+READ_LAT+1; for defaults this is cycle 515.
- All outputs are registered. `q` is sampled only at delay-line-valid edges.

## Configuration
- `RAM_BIST_ERRLOG_EN`
  - **Defined:** `err_cnt` counts every mismatch. `err_addr` captures the address of the first mismatch only and is not overwritten afterwards.
  - **Undefined:** `err_cnt` and `err_addr` are tied to 0. A single sticky fail flag drives `pass`. The counter and capture registers are removed.

## Structure
- Package `ram_bist_pkg`: state enum (IDLE, WRITE, READ, DRAIN, DONE), default widths, default SEED.
- Sub-module `ram_bist_dly`: a READ_LAT-stage {valid, addr} shift register with synchronous clear. It is the only natural split.

## Test plan
- **Ideal RAM model, READ_LAT=2, DEPTH=256, SEED=8'h5A:** pulse `start` → writes of addr 0 → 8'h5A and addr 255 → 8'h59; `done` at cycle 515; `pass`=1; `err_cnt`=0.
- **Model corrupts addr 8'h10 read to 8'h00:** → `pass`=0, `err_cnt`=1, `err_addr`=8'h10.
- **Stuck-at-0 model (all reads 0):** → `err_cnt`=255, since only addr 8'hA6 matches (8'hA6+8'h5A = 0); `err_addr`=0.
- **`start` re-pulsed at cycle 100 mid-WRITE:** → ignored; `done` still at cycle 515. A second `start` while in DONE clears `done` and reruns.
- **`rst_n` asserted during READ:** → all outputs 0 that cycle; a subsequent `start` completes with `pass`=1.
- **READ_LAT=1, DEPTH=4:** → `done` at cycle 10; compares aligned with `pass`=1.
